mips_mmio_responder: RTL and testbench
======================================

// Module: mips_mmio_responder
// PURPOSE
//  Responder on the single-cycle CPU data port: decodes memwrite/aluout/writedata, returns readdata the same cycle.
//  Hosts console TX FIFO (drained by valid/ready sink), free-running cycle counter, compare timer with irq.
//  Sits beside data memory in the top level; top muxes readdata by sel.
// PARAMETERS
//  BASE_ADDR   32'hFFFF_FF00  window base; hit when addr[31:8]==BASE_ADDR[31:8]
//  FIFO_DEPTH  8              console FIFO entries, power of two, >=2
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-low reset
//  memwrite   in   1   CPU store strobe
//  addr       in   32  CPU aluout (byte address, word-aligned use)
//  writedata  in   32  CPU store data
//  readdata   out  32  load data, combinational from addr
//  sel        out  1   addr hits window (combinational)
//  tx_data    out  8   FIFO head byte
//  tx_valid   out  1   FIFO not empty
//  tx_ready   in   1   sink accepts head this cycle
//  irq        out  1   timer interrupt
// BEHAVIOUR
//  Map (offset=addr[7:0]): 0x00 DATA W:push writedata[7:0], R:0 | 0x04 STATUS R:{16'b0,count[7:0],5'b0,ovf,empty,full},
//   W:writedata[2]=1 clears ovf | 0x08 CYCLE R only | 0x0C CMP R/W | 0x10 CTRL R:{30'b0,flag,en}, W:en=wd[0], wd[1]=1 clears flag.
//  Unmapped offsets in window: read 0, writes ignored. sel=0: readdata=0, no state change.
//  Writes commit on rising clk when memwrite&sel; reads reflect pre-edge state. addr[1:0] ignored.
//  Reset: FIFO empty (ptrs/count 0), ovf 0, CYCLE 0, CMP 0, en 0, flag 0; tx_valid 0, irq 0, readdata 0 unless sel.
//  FIFO: pop when tx_valid&tx_ready; tx_data from storage at head (no bubble). Ptrs wrap mod FIFO_DEPTH;
//   count width $clog2(FIFO_DEPTH)+1, STATUS count zero-extended/truncated to 8 bits.
//  Push when full and no pop: byte dropped, ovf set (sticky). Push+pop same cycle when full: both occur, count unchanged.
//  Push when empty: tx_valid rises next cycle (no same-cycle fall-through). ovf set+clear same cycle: set wins.
//  CYCLE: +1 every cycle, 0xFFFF_FFFF wraps to 0.
//  Timer: flag set on edge where en=1 and CYCLE==CMP (pre-increment value); sticky until W1C; set beats clear.
//  irq = flag & en (registered-state combinational). Writing en=0 masks irq, keeps flag.
//  Reset asserted mid-operation: all state cleared immediately; queued bytes lost.
// CONFIGURATION
//  MIPS_MMIO_TIMER_EN defined: CMP/CTRL/flag/irq as above.
//  Undefined: CMP and CTRL read 0, writes ignored, irq tied 0; CYCLE counter and FIFO unchanged.
// STRUCTURE
//  mips_mmio_pkg: offset localparams (OFF_DATA..OFF_CTRL), STATUS/CTRL bit indices.
//  Sub-module mips_sync_fifo #(WIDTH=8,DEPTH): push/pop/full/empty/count; responder owns decode, ovf, counter, timer.
// TESTING
//  Reset low then high -> all regs read 0, tx_valid=0, irq=0, CYCLE reads 1 one cycle after release.
//  Store 0x41,0x42 to DATA, tx_ready=0 -> STATUS=0x0000_0200; tx_ready=1 -> tx_data 0x41 then 0x42, then empty.
//  9 stores, DEPTH=8, tx_ready=0 -> full=1, ovf=1, 9th byte absent; W 0x4 to STATUS -> ovf=0.
//  Full FIFO, store + tx_ready=1 same cycle -> count stays 8, new byte emerges last.
//  CMP=20, CTRL=1 -> irq=1 after edge where CYCLE==20; W CTRL=0x3 -> irq=0; CTRL=0 masks flag.
//  Store to addr 0x0000_0004 -> sel=0, no state change; without MIPS_MMIO_TIMER_EN, CMP reads 0, irq=0.

Source files
------------

// File: rtl/mips_mmio_pkg.sv
// Shared register map for the MIPS MMIO responder window.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mips_mmio_pkg;

  // Word offsets inside the 256-byte window (addr[7:0] with addr[1:0] forced to 0)
  localparam logic [7:0] OFF_DATA   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_CYCLE  = 8'h08;
  localparam logic [7:0] OFF_CMP    = 8'h0C;
  localparam logic [7:0] OFF_CTRL   = 8'h10;

  // STATUS bit positions
  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 8;

  // CTRL bit positions
  localparam int CTRL_EN   = 0;
  localparam int CTRL_FLAG = 1;

endpackage

// File: rtl/mips_sync_fifo.sv
// Synchronous FIFO with occupancy count; head word is always visible on head.
// Latency: a push becomes visible on head/empty the cycle after it is written.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
module mips_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop frees a slot in the same edge, so a full FIFO still takes the push.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mips_mmio_responder.sv
// MMIO responder: console TX FIFO, free-running cycle counter, compare timer (MIPS_MMIO_TIMER_EN).
// Latency: readdata/sel combinational from addr; stores commit on the next rising clk.
// Backpressure: tx_valid/tx_ready drain; stores to a full FIFO with no pop are dropped and set ovf.
module mips_mmio_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FF00,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        sel,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq
);
  import mips_mmio_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    off;
  logic          wr_en;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [31:0]   cnt_ext;
  logic          ovf;
  logic [31:0]   cycle;
  logic [31:0]   status_word;
  logic          unused_bits;

  assign sel      = (addr[31:8] == BASE_ADDR[31:8]);
  assign off      = {addr[7:2], 2'b00};
  assign wr_en    = memwrite & sel;
  assign push     = wr_en & (off == OFF_DATA);
  assign tx_valid = ~empty;
  assign pop      = tx_valid & tx_ready;
  assign cnt_ext  = 32'(count);
  assign unused_bits = ^{addr[1:0], writedata};

  mips_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (writedata[7:0]),
    .pop       (pop),
    .head      (tx_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Sticky overflow: a dropped byte sets it, W1C clears it, set has priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf <= 1'b0;
    end else if (push & full & ~pop) begin
      ovf <= 1'b1;
    end else if (wr_en && (off == OFF_STATUS) && writedata[ST_OVF]) begin
      ovf <= 1'b0;
    end
  end

  // Free-running cycle counter, wraps at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle <= '0;
    end else begin
      cycle <= cycle + 32'd1;
    end
  end

  // STATUS word assembly; count is zero-extended or truncated to 8 bits.
  always_comb begin
    status_word                       = '0;
    status_word[ST_FULL]              = full;
    status_word[ST_EMPTY]             = empty;
    status_word[ST_OVF]               = ovf;
    status_word[ST_CNT_LSB +: 8]      = cnt_ext[7:0];
  end

`ifdef MIPS_MMIO_TIMER_EN
  logic [31:0] cmp;
  logic        en;
  logic        flag;
  logic        ctrl_wr;
  logic        match;
  logic [31:0] ctrl_word;

  assign ctrl_wr = wr_en && (off == OFF_CTRL);
  // Match uses the pre-increment counter and the pre-edge enable.
  assign match   = en && (cycle == cmp);
  assign irq     = flag & en;

  // Compare register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmp <= '0;
    end else if (wr_en && (off == OFF_CMP)) begin
      cmp <= writedata;
    end
  end

  // Enable and sticky match flag; a match on the same edge beats a W1C.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en   <= 1'b0;
      flag <= 1'b0;
    end else begin
      if (ctrl_wr) en <= writedata[CTRL_EN];
      flag <= match | (flag & ~(ctrl_wr & writedata[CTRL_FLAG]));
    end
  end

  // CTRL word assembly.
  always_comb begin
    ctrl_word            = '0;
    ctrl_word[CTRL_EN]   = en;
    ctrl_word[CTRL_FLAG] = flag;
  end
`else
  assign irq = 1'b0;
`endif

  // Load data mux; anything outside the window or unmapped reads 0.
  always_comb begin
    readdata = '0;
    if (sel) begin
      case (off)
        OFF_STATUS: readdata = status_word;
        OFF_CYCLE:  readdata = cycle;
`ifdef MIPS_MMIO_TIMER_EN
        OFF_CMP:    readdata = cmp;
        OFF_CTRL:   readdata = ctrl_word;
`endif
        default:    readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mmio_responder.sv
// Bench for mips_mmio_responder: directed scenarios plus random traffic against a queue-based model.
// Latency: inputs driven 1ns after rising edge, outputs checked on the falling edge.
// Backpressure: tx_ready randomized; TX bytes checked by an independent scoreboard monitor.
module tb_mips_mmio_responder;

  localparam logic [31:0] BASE  = 32'hFFFF_FF00;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] writedata = '0;
  logic        tx_ready = 1'b0;
  logic [31:0] readdata;
  logic        sel;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        irq;

  always #5 clk = ~clk;

  mips_mmio_responder #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .addr      (addr),
    .writedata (writedata),
    .readdata  (readdata),
    .sel       (sel),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .irq       (irq)
  );

  // Reference model state
  logic [7:0]  mq[$];
  logic [7:0]  sb[$];
  logic        m_ovf;
  logic [31:0] m_cycle;
  logic [31:0] m_cmp;
  logic        m_en;
  logic        m_flag;

  int total  = 0;
  int passed = 0;

  function automatic logic [31:0] b2w(input logic b);
    return {31'b0, b};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic m_hit(input logic [31:0] a);
    return (a & 32'hFFFF_FF00) == BASE;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [7:0] o;
    o = a[7:0] & 8'hFC;
    if (!m_hit(a)) return 32'h0;
    case (o)
      8'h04: return {16'h0, 8'(mq.size()), 5'b0, m_ovf, mq.size() == 0, mq.size() == DEPTH};
      8'h08: return m_cycle;
`ifdef MIPS_MMIO_TIMER_EN
      8'h0C: return m_cmp;
      8'h10: return {30'b0, m_flag, m_en};
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    mq.delete();
    sb.delete();
    m_ovf = 1'b0; m_cycle = '0; m_cmp = '0; m_en = 1'b0; m_flag = 1'b0;
  endtask

  // Apply one clock edge worth of architectural effect.
  task automatic m_edge(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic rdy);
    logic       w, full, pop, push, ovf_set, hitcmp, clr;
    logic [7:0] o;
    w       = we && m_hit(a);
    o       = a[7:0] & 8'hFC;
    full    = (mq.size() == DEPTH);
    pop     = (mq.size() > 0) && rdy;
    push    = w && (o == 8'h00);
    ovf_set = push && full && !pop;
    if (pop) void'(mq.pop_front());
    if (push && (!full || pop)) begin
      mq.push_back(wd[7:0]);
      sb.push_back(wd[7:0]);
    end
    if (ovf_set) m_ovf = 1'b1;
    else if (w && o == 8'h04 && wd[2]) m_ovf = 1'b0;
    hitcmp = 1'b0;
    clr    = 1'b0;
`ifdef MIPS_MMIO_TIMER_EN
    hitcmp = m_en && (m_cycle == m_cmp);
    if (w && o == 8'h10) begin
      clr  = wd[1];
      m_en = wd[0];
    end
    if (w && o == 8'h0C) m_cmp = wd;
    m_flag = hitcmp | (m_flag & !clr);
`endif
    m_cycle = m_cycle + 32'd1;
  endtask

  // One bus cycle: drive, check combinational outputs mid-cycle, advance the model at the edge.
  task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic rdy);
    memwrite = we; addr = a; writedata = wd; tx_ready = rdy;
    @(negedge clk);
    chk("sel", b2w(sel), b2w(m_hit(a)));
    chk($sformatf("readdata@%08h", a), readdata, m_read(a));
    chk("tx_valid", b2w(tx_valid), b2w(mq.size() > 0));
    chk("irq", b2w(irq), b2w(m_flag & m_en));
    @(posedge clk);
    m_edge(we, a, wd, rdy);
    #1;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    memwrite = 1'b0; addr = a; writedata = '0; tx_ready = 1'b0;
    @(negedge clk);
    chk(name, readdata, exp);
    @(posedge clk);
    m_edge(1'b0, a, 32'h0, 1'b0);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, BASE + 32'h8, 32'h0, rdy);
  endtask

  task automatic do_reset();
    reset = 1'b0; memwrite = 1'b0; tx_ready = 1'b0; addr = BASE + 32'h4;
    m_reset();
    #2;
    chk("reset_tx_valid", b2w(tx_valid), 32'h0);
    chk("reset_irq", b2w(irq), 32'h0);
    chk("reset_status", readdata, 32'h0000_0002);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Scoreboard monitor: every accepted TX byte must match the next expected one.
  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (reset && tx_valid && tx_ready) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL tx_unexpected: got 0x%02h expected no byte", tx_data);
        end else begin
          e = sb.pop_front();
          chk("tx_data", {24'h0, tx_data}, {24'h0, e});
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int offs [9] = '{0, 0, 0, 4, 8, 'hC, 'h10, 'h14, 'hFC};
    logic [31:0] a, wd;
    logic we, rdy;
    int k;

    m_reset();
    #3;
    do_reset();

    // Reset state and counter start
    rd_chk("cycle_at_release", BASE + 32'h8, 32'h0);
    rd_chk("cycle_after_release", BASE + 32'h8, 32'h1);
    rd_chk("reset_data", BASE + 32'h0, 32'h0);
    rd_chk("reset_cmp", BASE + 32'hC, 32'h0);
    rd_chk("reset_ctrl", BASE + 32'h10, 32'h0);

    // Two bytes held, then drained in order
    cyc(1'b1, BASE, 32'h0000_0041, 1'b0);
    cyc(1'b1, BASE + 32'h1, 32'hABCD_0042, 1'b0);
    rd_chk("status_two", BASE + 32'h4, 32'h0000_0200);
    idle(4, 1'b1);
    rd_chk("status_drained", BASE + 32'h4, 32'h0000_0002);

    // Overflow on the 9th byte, then W1C
    for (int i = 0; i < 9; i++) cyc(1'b1, BASE, 32'h50 + i, 1'b0);
    rd_chk("status_full_ovf", BASE + 32'h4, 32'h0000_0805);
    cyc(1'b1, BASE + 32'h4, 32'h4, 1'b0);
    rd_chk("status_ovf_clr", BASE + 32'h4, 32'h0000_0801);

    // Push and pop together on a full FIFO
    cyc(1'b1, BASE, 32'h99, 1'b1);
    rd_chk("status_full_pushpop", BASE + 32'h4, 32'h0000_0801);
    idle(10, 1'b1);
    chk("sb_empty_after_drain", sb.size(), 32'h0);

    // Compare timer
    cyc(1'b1, BASE + 32'hC, m_cycle + 32'd6, 1'b0);
    cyc(1'b1, BASE + 32'h10, 32'h1, 1'b0);
    idle(8, 1'b0);
`ifdef MIPS_MMIO_TIMER_EN
    chk("irq_after_cmp", b2w(irq), 32'h1);
`else
    chk("irq_no_timer", b2w(irq), 32'h0);
`endif
    cyc(1'b1, BASE + 32'h10, 32'h3, 1'b0);
    chk("irq_after_w1c", b2w(irq), 32'h0);
    cyc(1'b1, BASE + 32'hC, m_cycle + 32'd3, 1'b0);
    idle(5, 1'b0);
    cyc(1'b1, BASE + 32'h10, 32'h0, 1'b0);
    chk("irq_masked", b2w(irq), 32'h0);
`ifdef MIPS_MMIO_TIMER_EN
    rd_chk("ctrl_flag_kept", BASE + 32'h10, 32'h2);
`else
    rd_chk("cmp_reads_zero", BASE + 32'hC, 32'h0);
`endif

    // Store outside the window
    cyc(1'b1, 32'h0000_0004, 32'h77, 1'b0);
    rd_chk("status_after_miss", BASE + 32'h4, 32'h0000_0002);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      k  = $urandom_range(0, 9);
      if (k == 9) a = ($urandom_range(0, 1) == 0) ? 32'h0000_0004 : $urandom;
      else a = BASE | offs[k] | $urandom_range(0, 3);
      we  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      if ((a[7:0] & 8'hFC) == 8'h0C) wd = m_cycle + $urandom_range(1, 10);
      rdy = ($urandom_range(0, 99) < ((i < 300) ? 25 : 70));
      cyc(we, a, wd, rdy);
    end

    // Reset with bytes queued
    cyc(1'b1, BASE, 32'hA1, 1'b0);
    cyc(1'b1, BASE, 32'hA2, 1'b0);
    cyc(1'b1, BASE + 32'h10, 32'h1, 1'b0);
    do_reset();
    idle(3, 1'b1);
    rd_chk("status_after_midreset", BASE + 32'h4, 32'h0000_0002);

    idle(12, 1'b1);
    chk("sb_empty_final", sb.size(), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
